dm_port_arbiter: RTL and testbench

- Shares the single-port data memory between two requesters: the CPU data port (c_*) and the peripheral/bridge port (b_*).
- Arbitrates between them, sequences each access through a fixed 3-state FSM, and generates byte enables and lane-aligned write data from word mode and address.
- Extracts and extends sub-word read data before returning it.
- Sits between the MEM stage / bridge and the data memory array.

---
 rtl/dm_port_arbiter_pkg.sv | 25 ++
 rtl/dm_port_arbiter_lane_unit.sv | 52 +++++
 rtl/dm_port_arbiter.sv | 158 +++++++++++++++
 tb/tb_dm_port_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/dm_port_arbiter_pkg.sv
// Shared encodings for the data-memory port arbiter: word modes, FSM states, owner ids.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dm_port_arbiter_pkg;

    // Access sequencing states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_RESP = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    // Word modes: full word, half unsigned/signed, byte unsigned/signed
    localparam logic [2:0] WM_WD = 3'd0;
    localparam logic [2:0] WM_HU = 3'd1;
    localparam logic [2:0] WM_HS = 3'd2;
    localparam logic [2:0] WM_BU = 3'd3;
    localparam logic [2:0] WM_BS = 3'd4;

    // Requester ids
    localparam logic OWN_C = 1'b0;
    localparam logic OWN_B = 1'b1;

endpackage

// File: rtl/dm_port_arbiter_lane_unit.sv
// Lane steering: byte enables, replicated write data, sub-word read extract, misalign flag.
// Latency: purely combinational.
// Backpressure: none; follows its inputs.
module dm_lane_unit
    import dm_port_arbiter_pkg::*;
(
    input  logic [2:0]  wm,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_al,
    output logic [31:0] rdata_ext,
    output logic        misalign
);

    logic [15:0] hsel;
    logic [7:0]  bsel;

    // Lane picked out of the returned word for half and byte loads
    assign hsel = addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    assign bsel = 8'(mem_rdata >> {addr, 3'b000});

    // Decode word mode into enables, write replication and read extension;
    // unknown modes produce no enables and a zero read result
    always_comb begin
        be        = 4'b0000;
        wdata_al  = wdata;
        rdata_ext = 32'h0;
        misalign  = 1'b0;
        case (wm)
            WM_WD: begin
                be        = 4'b1111;
                rdata_ext = mem_rdata;
                misalign  = (addr != 2'b00);
            end
            WM_HU, WM_HS: begin
                be        = addr[1] ? 4'b1100 : 4'b0011;
                wdata_al  = {2{wdata[15:0]}};
                rdata_ext = (wm == WM_HS) ? {{16{hsel[15]}}, hsel} : {16'h0, hsel};
                misalign  = addr[0];
            end
            WM_BU, WM_BS: begin
                be        = 4'b0001 << addr;
                wdata_al  = {4{wdata[7:0]}};
                rdata_ext = (wm == WM_BS) ? {{24{bsel[7]}}, bsel} : {24'h0, bsel};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dm_port_arbiter.sv
// Two-requester arbiter (CPU c_*, bridge b_*) in front of a single-port synchronous data memory.
// Latency: request seen in IDLE at edge N -> done/err registered at edge N+2 / N+1; one access per 3 cycles.
// Backpressure: requesters hold req and fields until done/err; the tie loser waits for the next IDLE.
module dm_port_arbiter
    import dm_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [2:0]        c_wm,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [31:0]       c_wdata,
    output logic              c_done,
    output logic              c_err,
    output logic [31:0]       c_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [2:0]        b_wm,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [31:0]       b_wdata,
    output logic              b_done,
    output logic              b_err,
    output logic [31:0]       b_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    state_t            state;
    logic              owner;
    logic              rr_last;
    logic              lat_we;
    logic [2:0]        lat_wm;
    logic [ADDR_W-1:0] lat_addr;
    logic [31:0]       lat_wdata;

    logic              win;
    logic              win_we;
    logic [2:0]        win_wm;
    logic [ADDR_W-1:0] win_addr;
    logic [31:0]       win_wdata;
    logic              idle;
    logic              acc;

    logic [2:0]        sel_wm;
    logic [1:0]        sel_addr;
    logic [31:0]       sel_wdata;
    logic [3:0]        lane_be;
    logic [31:0]       lane_wdata;
    logic [31:0]       lane_rdata;
    logic              lane_mis;

    assign idle = (state == ST_IDLE);
    assign acc  = (state == ST_ACC);

    // Winner selection: c by default, the other port than last time on a round-robin tie
    always_comb begin
        win = OWN_C;
        if (c_req && b_req) begin
            win = FIXED_PRIO ? OWN_C : ~rr_last;
        end else if (b_req) begin
            win = OWN_B;
        end
    end

    assign win_we    = (win == OWN_B) ? b_we    : c_we;
    assign win_wm    = (win == OWN_B) ? b_wm    : c_wm;
    assign win_addr  = (win == OWN_B) ? b_addr  : c_addr;
    assign win_wdata = (win == OWN_B) ? b_wdata : c_wdata;

    // The lane unit sees the live winner in IDLE (for the misalign decision)
    // and the latched access in every other state
    assign sel_wm    = idle ? win_wm          : lat_wm;
    assign sel_addr  = idle ? win_addr[1:0]   : lat_addr[1:0];
    assign sel_wdata = idle ? win_wdata       : lat_wdata;

    dm_lane_unit u_lane (
        .wm        (sel_wm),
        .addr      (sel_addr),
        .wdata     (sel_wdata),
        .mem_rdata (mem_rdata),
        .be        (lane_be),
        .wdata_al  (lane_wdata),
        .rdata_ext (lane_rdata),
        .misalign  (lane_mis)
    );

    // Memory strobe and fields exist only during the single ACC cycle
    assign mem_en    = acc;
    assign mem_we    = acc & lat_we;
    assign mem_be    = acc ? lane_be : 4'b0000;
    assign mem_addr  = acc ? lat_addr[ADDR_W-1:2] : '0;
    assign mem_wdata = acc ? lane_wdata : 32'h0;

    // Access sequencer: grant/latch, memory cycle, response or error pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            owner     <= OWN_C;
            rr_last   <= OWN_B;
            lat_we    <= 1'b0;
            lat_wm    <= 3'd0;
            lat_addr  <= '0;
            lat_wdata <= 32'h0;
            c_done    <= 1'b0;
            c_err     <= 1'b0;
            c_rdata   <= 32'h0;
            b_done    <= 1'b0;
            b_err     <= 1'b0;
            b_rdata   <= 32'h0;
        end else begin
            c_done  <= 1'b0;
            c_err   <= 1'b0;
            c_rdata <= 32'h0;
            b_done  <= 1'b0;
            b_err   <= 1'b0;
            b_rdata <= 32'h0;
            case (state)
                ST_IDLE: begin
                    if (c_req || b_req) begin
                        owner     <= win;
                        rr_last   <= win;
                        lat_we    <= win_we;
                        lat_wm    <= win_wm;
                        lat_addr  <= win_addr;
                        lat_wdata <= win_wdata;
                        state     <= lane_mis ? ST_ERR : ST_ACC;
                    end
                end
                ST_ACC: state <= ST_RESP;
                ST_RESP: begin
                    if (owner == OWN_C) begin
                        c_done  <= 1'b1;
                        c_rdata <= lat_we ? 32'h0 : lane_rdata;
                    end else begin
                        b_done  <= 1'b1;
                        b_rdata <= lat_we ? 32'h0 : lane_rdata;
                    end
                    state <= ST_IDLE;
                end
                ST_ERR: begin
                    if (owner == OWN_C) c_err <= 1'b1;
                    else                b_err <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_port_arbiter.sv
module tb_dm_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        c_req = 1'b0, c_we = 1'b0;
    logic [2:0]  c_wm = 3'd0;
    logic [31:0] c_addr = 32'h0, c_wdata = 32'h0;
    logic        c_done, c_err;
    logic [31:0] c_rdata;
    logic        b_req = 1'b0, b_we = 1'b0;
    logic [2:0]  b_wm = 3'd0;
    logic [31:0] b_addr = 32'h0, b_wdata = 32'h0;
    logic        b_done, b_err;
    logic [31:0] b_rdata;
    logic        mem_en, mem_we;
    logic [3:0]  mem_be;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;

    int nvec = 0;
    int nerr = 0;

    dm_port_arbiter #(.ADDR_W(32), .FIXED_PRIO(1'b0)) dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_wm(c_wm), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_done(c_done), .c_err(c_err), .c_rdata(c_rdata),
        .b_req(b_req), .b_we(b_we), .b_wm(b_wm), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_done(b_done), .b_err(b_err), .b_rdata(b_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous single-port memory model, 64 words
    logic [31:0] mem [0:63];
    initial for (int i = 0; i < 64; i++) mem[i] = 32'h0;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int i = 0; i < 4; i++)
                    if (mem_be[i]) mem[mem_addr[5:0]][8*i +: 8] <= mem_wdata[8*i +: 8];
            end else begin
                mem_rdata <= mem[mem_addr[5:0]];
            end
        end
    end

    // Observe ACC cycles and done overlap away from the active edge
    int          men_cnt = 0;
    int          ovl_cnt = 0;
    logic [3:0]  last_be;
    logic [29:0] last_addr;
    logic [31:0] last_wdata;
    logic        last_we;
    always @(negedge clk) begin
        if (mem_en) begin
            men_cnt    <= men_cnt + 1;
            last_be    <= mem_be;
            last_addr  <= mem_addr;
            last_wdata <= mem_wdata;
            last_we    <= mem_we;
        end
        if (c_done && b_done) ovl_cnt <= ovl_cnt + 1;
    end

    // Drive one access on a port and wait (bounded) for its done/err pulse
    task automatic access(input bit port, input bit we, input logic [2:0] wm,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output bit got_done, output bit got_err,
                          output logic [31:0] rdata, output int n);
        got_done = 1'b0; got_err = 1'b0; rdata = 32'h0; n = 0;
        if (port == 1'b0) begin
            c_req = 1'b1; c_we = we; c_wm = wm; c_addr = addr; c_wdata = wdata;
        end else begin
            b_req = 1'b1; b_we = we; b_wm = wm; b_addr = addr; b_wdata = wdata;
        end
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            n++;
            got_done = (port == 1'b0) ? c_done : b_done;
            got_err  = (port == 1'b0) ? c_err  : b_err;
            rdata    = (port == 1'b0) ? c_rdata : b_rdata;
            if (got_done || got_err) break;
        end
        if (port == 1'b0) c_req = 1'b0; else b_req = 1'b0;
    endtask

    bit          d, e;
    logic [31:0] r;
    int          n;

    task automatic test_reset();
        repeat (3) @(negedge clk);
        nvec++; if ({c_done, c_err, b_done, b_err} !== 4'b0) begin nerr++; $display("FAIL reset_pulses got %b exp 0000", {c_done, c_err, b_done, b_err}); end
        nvec++; if ({c_rdata, b_rdata} !== 64'h0) begin nerr++; $display("FAIL reset_rdata got %h exp 0", {c_rdata, b_rdata}); end
        nvec++; if ({mem_en, mem_we, mem_be, mem_addr, mem_wdata} !== 68'h0) begin nerr++; $display("FAIL reset_mem got %h exp 0", {mem_en, mem_we, mem_be, mem_addr, mem_wdata}); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_word();
        access(1'b0, 1'b1, 3'd0, 32'h10, 32'hDEADBEEF, d, e, r, n);
        nvec++; if (d !== 1'b1 || n != 3) begin nerr++; $display("FAIL wd_store_done got done=%b n=%0d exp done=1 n=3", d, n); end
        nvec++; if (last_be !== 4'b1111 || last_we !== 1'b1) begin nerr++; $display("FAIL wd_store_be got be=%b we=%b exp 1111 1", last_be, last_we); end
        nvec++; if (last_addr !== 30'h4) begin nerr++; $display("FAIL wd_store_addr got %h exp 4", last_addr); end
        nvec++; if (last_wdata !== 32'hDEADBEEF) begin nerr++; $display("FAIL wd_store_wdata got %h exp deadbeef", last_wdata); end
        access(1'b0, 1'b0, 3'd0, 32'h10, 32'h0, d, e, r, n);
        nvec++; if (r !== 32'hDEADBEEF || d !== 1'b1) begin nerr++; $display("FAIL wd_load got %h exp deadbeef", r); end
    endtask

    task automatic test_byte();
        access(1'b0, 1'b1, 3'd3, 32'h13, 32'h000000A5, d, e, r, n);
        nvec++; if (last_be !== 4'b1000) begin nerr++; $display("FAIL bu_store_be got %b exp 1000", last_be); end
        nvec++; if (last_wdata !== 32'hA5A5A5A5) begin nerr++; $display("FAIL bu_store_wdata got %h exp a5a5a5a5", last_wdata); end
        access(1'b0, 1'b0, 3'd4, 32'h13, 32'h0, d, e, r, n);
        nvec++; if (r !== 32'hFFFFFFA5) begin nerr++; $display("FAIL bs_load got %h exp ffffffa5", r); end
        access(1'b0, 1'b0, 3'd3, 32'h13, 32'h0, d, e, r, n);
        nvec++; if (r !== 32'h000000A5) begin nerr++; $display("FAIL bu_load got %h exp 000000a5", r); end
        access(1'b0, 1'b0, 3'd0, 32'h10, 32'h0, d, e, r, n);
        nvec++; if (r !== 32'hA5ADBEEF) begin nerr++; $display("FAIL byte_merge got %h exp a5adbeef", r); end
        access(1'b0, 1'b0, 3'd3, 32'h10, 32'h0, d, e, r, n);
        nvec++; if (r !== 32'h000000EF) begin nerr++; $display("FAIL bu_lane0 got %h exp 000000ef", r); end
    endtask

    task automatic test_half();
        access(1'b1, 1'b1, 3'd1, 32'h22, 32'h12348001, d, e, r, n);
        nvec++; if (last_be !== 4'b1100 || last_wdata !== 32'h80018001) begin nerr++; $display("FAIL hu_store_hi got be=%b wd=%h exp 1100 80018001", last_be, last_wdata); end
        access(1'b1, 1'b1, 3'd2, 32'h20, 32'h00007FFF, d, e, r, n);
        nvec++; if (last_be !== 4'b0011 || d !== 1'b1) begin nerr++; $display("FAIL hs_store_lo got be=%b done=%b exp 0011 1", last_be, d); end
        access(1'b0, 1'b0, 3'd0, 32'h20, 32'h0, d, e, r, n);
        nvec++; if (r !== 32'h80017FFF) begin nerr++; $display("FAIL half_word got %h exp 80017fff", r); end
        access(1'b0, 1'b0, 3'd2, 32'h22, 32'h0, d, e, r, n);
        nvec++; if (r !== 32'hFFFF8001) begin nerr++; $display("FAIL hs_load got %h exp ffff8001", r); end
        access(1'b1, 1'b0, 3'd1, 32'h20, 32'h0, d, e, r, n);
        nvec++; if (r !== 32'h00007FFF || d !== 1'b1) begin nerr++; $display("FAIL hu_load got %h exp 00007fff", r); end
        access(1'b0, 1'b0, 3'd1, 32'h22, 32'h0, d, e, r, n);
        nvec++; if (r !== 32'h00008001) begin nerr++; $display("FAIL hu_load_hi got %h exp 00008001", r); end
        access(1'b0, 1'b0, 3'd4, 32'h23, 32'h0, d, e, r, n);
        nvec++; if (r !== 32'hFFFFFF80) begin nerr++; $display("FAIL bs_load_top got %h exp ffffff80", r); end
    endtask

    task automatic test_misalign();
        int m0;
        m0 = men_cnt;
        access(1'b1, 1'b0, 3'd0, 32'h06, 32'h0, d, e, r, n);
        nvec++; if (e !== 1'b1 || d !== 1'b0 || n != 2) begin nerr++; $display("FAIL wd_misalign got err=%b done=%b n=%0d exp 1 0 2", e, d, n); end
        access(1'b1, 1'b0, 3'd1, 32'h01, 32'h0, d, e, r, n);
        nvec++; if (e !== 1'b1 || d !== 1'b0) begin nerr++; $display("FAIL hu_misalign got err=%b done=%b exp 1 0", e, d); end
        nvec++; if (men_cnt != m0) begin nerr++; $display("FAIL misalign_mem_en got %0d exp %0d", men_cnt, m0); end
        access(1'b0, 1'b0, 3'd3, 32'h13, 32'h0, d, e, r, n);
        nvec++; if (e !== 1'b0 || r !== 32'h000000A5) begin nerr++; $display("FAIL byte_odd_ok got err=%b r=%h exp 0 000000a5", e, r); end
    endtask

    task automatic test_undef_wm();
        access(1'b0, 1'b1, 3'd7, 32'h10, 32'h12345678, d, e, r, n);
        nvec++; if (d !== 1'b1 || last_be !== 4'b0000) begin nerr++; $display("FAIL undef_wm got done=%b be=%b exp 1 0000", d, last_be); end
        access(1'b0, 1'b0, 3'd0, 32'h10, 32'h0, d, e, r, n);
        nvec++; if (r !== 32'hA5ADBEEF) begin nerr++; $display("FAIL undef_wm_nowrite got %h exp a5adbeef", r); end
    endtask

    task automatic test_round_robin();
        int cd, bd, k, ov0;
        bit          seq [0:7];
        int          tim [0:7];
        reset = 1'b0; @(negedge clk); reset = 1'b1; @(negedge clk);
        ov0 = ovl_cnt;
        c_req = 1'b1; c_we = 1'b1; c_wm = 3'd0; c_addr = 32'h30; c_wdata = 32'hC0C0C0C0;
        b_req = 1'b1; b_we = 1'b1; b_wm = 3'd0; b_addr = 32'h34; b_wdata = 32'hB0B0B0B0;
        cd = 0; bd = 0; k = 0;
        for (int t = 0; t < 60 && (cd < 4 || bd < 4); t++) begin
            @(negedge clk);
            if (c_done && k < 8) begin seq[k] = 1'b0; tim[k] = t; k++; cd++; if (cd == 4) c_req = 1'b0; end
            if (b_done && k < 8) begin seq[k] = 1'b1; tim[k] = t; k++; bd++; if (bd == 4) b_req = 1'b0; end
        end
        c_req = 1'b0; b_req = 1'b0;
        nvec++; if (k != 8) begin nerr++; $display("FAIL rr_count got %0d exp 8", k); end
        for (int i = 0; i < k; i++) begin
            nvec++; if (seq[i] !== 1'(i % 2)) begin nerr++; $display("FAIL rr_order[%0d] got %0d exp %0d", i, seq[i], i % 2); end
        end
        for (int i = 1; i < k; i++) begin
            nvec++; if (tim[i] - tim[i-1] != 3) begin nerr++; $display("FAIL rr_spacing[%0d] got %0d exp 3", i, tim[i] - tim[i-1]); end
        end
        nvec++; if (ovl_cnt != ov0) begin nerr++; $display("FAIL rr_overlap got %0d exp 0", ovl_cnt - ov0); end
        @(negedge clk);
    endtask

    task automatic test_abort_reset();
        int dseen;
        c_req = 1'b1; c_we = 1'b1; c_wm = 3'd0; c_addr = 32'h40; c_wdata = 32'h11112222;
        @(negedge clk);
        nvec++; if (mem_en !== 1'b1) begin nerr++; $display("FAIL abort_in_acc got %b exp 1", mem_en); end
        reset = 1'b0;
        #1;
        nvec++; if ({mem_en, mem_we, mem_be, mem_addr, mem_wdata} !== 68'h0) begin nerr++; $display("FAIL abort_mem got %h exp 0", {mem_en, mem_we, mem_be, mem_addr, mem_wdata}); end
        c_req = 1'b0;
        dseen = 0;
        repeat (4) begin @(negedge clk); if (c_done || c_err) dseen++; end
        reset = 1'b1;
        repeat (3) begin @(negedge clk); if (c_done || c_err) dseen++; end
        nvec++; if (dseen != 0) begin nerr++; $display("FAIL abort_no_done got %0d exp 0", dseen); end
        access(1'b0, 1'b0, 3'd0, 32'h40, 32'h0, d, e, r, n);
        nvec++; if (r !== 32'h00000000) begin nerr++; $display("FAIL abort_no_write got %h exp 0", r); end
        access(1'b0, 1'b1, 3'd0, 32'h40, 32'h11112222, d, e, r, n);
        nvec++; if (d !== 1'b1 || n != 3) begin nerr++; $display("FAIL reissue_done got done=%b n=%0d exp 1 3", d, n); end
        access(1'b0, 1'b0, 3'd0, 32'h40, 32'h0, d, e, r, n);
        nvec++; if (r !== 32'h11112222) begin nerr++; $display("FAIL reissue_load got %h exp 11112222", r); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_misalign();
        test_undef_wm();
        test_round_robin();
        test_abort_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
